// File: rtl/adder_pkg.sv
// Shared types for the streaming adder/accumulator: operation modes and mode decode.
package adder_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_mode_e;

    function automatic op_mode_e decode_mode(input logic [1:0] raw);
        return op_mode_e'(raw);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with asynchronous active-high reset, occupancy count and full/empty flags.
module sync_fifo #(
    parameter int unsigned W     = 9,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible until an entry has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/stream_adder_acc.sv
// Streaming ADD/SUB/ACC/CLR unit: valid/ready operand input, one result per accepted pair,
// results queued in an output FIFO with an overflow flag.
module stream_adder_acc
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned ACC_W    = 8,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned SATURATE = 0,
    localparam int unsigned LVL_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] y,
    output logic             ovf,
    output logic [LVL_W-1:0] level
);

    if (ACC_W < WIDTH + 1) begin : g_bad_acc_w
        $error("stream_adder_acc: ACC_W must be >= WIDTH+1");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("stream_adder_acc: DEPTH must be >= 1");
    end

    op_mode_e           op;
    logic               accept;
    logic [WIDTH:0]     sum_ab;
    logic signed [WIDTH:0] diff_s;
    logic [ACC_W:0]     acc_sum;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_next;
    logic [ACC_W-1:0]   res_y;
    logic               res_ovf;
    logic [ACC_W:0]     head;
    logic               fifo_full, fifo_empty;

    assign op      = decode_mode(mode);
    assign accept  = in_valid && in_ready;
    assign sum_ab  = {1'b0, a} + {1'b0, b};
    assign diff_s  = $signed({1'b0, a} - {1'b0, b});
    assign acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(a) + (ACC_W + 1)'(b);

    always_comb begin
        res_y    = '0;
        res_ovf  = 1'b0;
        acc_next = acc_q;
        unique case (op)
            OP_ADD: res_y = ACC_W'(sum_ab);
            OP_SUB: res_y = ACC_W'(diff_s);
            OP_ACC: begin
                res_ovf = acc_sum[ACC_W];
                if (acc_sum[ACC_W] && (SATURATE != 0)) acc_next = '1;
                else                                   acc_next = acc_sum[ACC_W-1:0];
                res_y = acc_next;
            end
            OP_CLR: acc_next = '0;
            default: ;
        endcase
    end

    assign acc_d = accept ? acc_next : acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    sync_fifo #(
        .W    (ACC_W + 1),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (accept),
        .wdata({res_ovf, res_y}),
        .pop  (out_valid && out_ready),
        .rdata(head),
        .full (fifo_full),
        .empty(fifo_empty),
        .level(level)
    );

    // No look-ahead at a same-cycle pop: a full FIFO stalls input for one cycle.
    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    assign y         = out_valid ? head[ACC_W-1:0] : '0;
    assign ovf       = out_valid ? head[ACC_W] : 1'b0;

endmodule

// File: tb/tb_stream_adder_acc.sv
// Self-checking bench for stream_adder_acc: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_stream_adder_acc;
    import adder_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, ovf;
    logic [3:0] a, b;
    logic [1:0] mode;
    logic [7:0] y;
    logic [1:0] level;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] y;
        logic       ovf;
    } vec_t;

    typedef struct {
        int y;
        bit ovf;
    } res_t;

    vec_t vecs[$];
    res_t q[$];
    int   macc;

    stream_adder_acc #(
        .WIDTH(4), .ACC_W(8), .DEPTH(2), .SATURATE(0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .mode     (mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .ovf      (ovf),
        .level    (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] m, input logic [3:0] av, input logic [3:0] bv);
        in_valid = 1'b1;
        mode     = m;
        a        = av;
        b        = bv;
    endtask

    // Reference behaviour from the arithmetic rules, using plain integers.
    function automatic res_t model_op(input logic [1:0] m, input int av, input int bv);
        res_t r;
        int   s;
        r.y   = 0;
        r.ovf = 1'b0;
        case (m)
            2'b00: r.y = av + bv;
            2'b01: r.y = (av - bv + 256) % 256;
            2'b10: begin
                s = macc + av + bv;
                if (s >= 256) begin
                    r.ovf = 1'b1;
                    s     = s - 256;
                end
                macc = s;
                r.y  = s;
            end
            default: macc = 0;
        endcase
        return r;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; mode = '0;

        // Reset state
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_ovf", ovf, 0);
        check("rst_level", level, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Vector table: ADD, SUB, CLR, ACC x17 to 255, 18th ACC wraps
        vecs.push_back('{OP_ADD, 4'd1, 4'd3, 8'd4, 1'b0});
        vecs.push_back('{OP_ADD, 4'd5, 4'd6, 8'd11, 1'b0});
        vecs.push_back('{OP_ADD, 4'd7, 4'd8, 8'd15, 1'b0});
        vecs.push_back('{OP_ADD, 4'd15, 4'd15, 8'd30, 1'b0});
        vecs.push_back('{OP_SUB, 4'd5, 4'd6, 8'hFF, 1'b0});
        vecs.push_back('{OP_SUB, 4'd9, 4'd2, 8'd7, 1'b0});
        vecs.push_back('{OP_CLR, 4'd3, 4'd4, 8'd0, 1'b0});
        for (int i = 1; i <= 17; i++) vecs.push_back('{OP_ACC, 4'd7, 4'd8, 8'(15 * i), 1'b0});
        vecs.push_back('{OP_ACC, 4'd7, 4'd8, 8'd14, 1'b1});
        vecs.push_back('{OP_ADD, 4'd2, 4'd2, 8'd4, 1'b0});
        vecs.push_back('{OP_ACC, 4'd0, 4'd1, 8'd15, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].mode, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_in_ready", i), in_ready, 1);
            tick();
            check($sformatf("vec%0d_out_valid", i), out_valid, 1);
            check($sformatf("vec%0d_y", i), y, vecs[i].y);
            check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
        end
        in_valid = 1'b0;
        tick();
        check("drain_out_valid", out_valid, 0);

        // Backpressure: fill, stall third pair, then drain in order
        out_ready = 1'b0;
        drive(OP_ADD, 4'd1, 4'd1);
        tick();
        drive(OP_ADD, 4'd2, 4'd2);
        tick();
        check("bp_level_full", level, 2);
        check("bp_in_ready_full", in_ready, 0);
        check("bp_head", y, 2);
        drive(OP_ADD, 4'd3, 4'd3);
        tick();
        check("bp_level_held", level, 2);
        check("bp_head_stable", y, 2);
        out_ready = 1'b1;
        check("bp_no_lookahead", in_ready, 0);
        tick();
        check("bp_second", y, 4);
        check("bp_level_after_pop", level, 1);
        check("bp_in_ready_back", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_third", y, 6);
        check("bp_level_pushpop", level, 1);
        tick();
        check("bp_empty", out_valid, 0);
        check("bp_level_empty", level, 0);

        // Push and pop in the same cycle at level 1
        out_ready = 1'b0;
        drive(OP_ADD, 4'd1, 4'd2);
        tick();
        in_valid = 1'b0;
        check("pp_level1", level, 1);
        check("pp_head", y, 3);
        out_ready = 1'b1;
        drive(OP_ADD, 4'd2, 4'd3);
        tick();
        in_valid = 1'b0;
        check("pp_level_kept", level, 1);
        check("pp_order", y, 5);
        tick();
        check("pp_level_drained", level, 0);

        // Reset mid-operation with a full FIFO and acc = 100
        drive(OP_CLR, 4'd0, 4'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(OP_ACC, 4'd15, 4'd15);
            tick();
        end
        drive(OP_ACC, 4'd5, 4'd5);
        tick();
        check("mr_acc100", y, 100);
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        drive(OP_ACC, 4'd0, 4'd0);
        tick();
        tick();
        in_valid = 1'b0;
        check("mr_level2", level, 2);
        check("mr_head", y, 100);
        #2;
        rst = 1'b1;
        #1;
        check("mr_out_valid", out_valid, 0);
        check("mr_level", level, 0);
        check("mr_y", y, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        drive(OP_ACC, 4'd1, 4'd1);
        tick();
        in_valid = 1'b0;
        check("mr_acc_cleared_y", y, 2);
        check("mr_acc_cleared_ovf", ovf, 0);
        tick();
        check("mr_drained", out_valid, 0);

        // Randomized traffic against the reference model
        macc = 2;
        for (int i = 0; i < 500; i++) begin
            bit   do_push, do_pop;
            res_t r;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            mode      = 2'($urandom);
            a         = 4'($urandom);
            b         = 4'($urandom);
            #1;
            check("rnd_level", level, q.size());
            check("rnd_in_ready", in_ready, q.size() < 2);
            check("rnd_out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                check("rnd_y", y, q[0].y);
                check("rnd_ovf", ovf, q[0].ovf);
            end
            do_pop  = out_ready && (q.size() != 0);
            do_push = in_valid && (q.size() < 2);
            r.y = 0;
            r.ovf = 1'b0;
            if (do_push) r = model_op(mode, int'(a), int'(b));
            @(posedge clk);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(r);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
